// File: rtl/dbg_port_arbiter.sv
// Round-robin arbiter sharing the core debug port between two debug requesters.
// Optional BUSY watchdog abort is enabled with `define DBG_ARB_TIMEOUT_EN.
module dbg_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int CMD_W  = 8
`ifdef DBG_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic [CMD_W-1:0]  m0_cmd_i,
   input  logic [DATA_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic [DATA_W-1:0] m0_data_o,
   output logic              m0_ready_o,
   input  logic [CMD_W-1:0]  m1_cmd_i,
   input  logic [DATA_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              m1_ready_o,
   output logic [CMD_W-1:0]  dbg_cmd_o,
   output logic [DATA_W-1:0] dbg_addr_o,
   output logic [DATA_W-1:0] dbg_data_o,
   input  logic [DATA_W-1:0] dbg_data_i,
   input  logic              dbg_ready_i,
   output logic              grant_o,
   output logic              busy_o
`ifdef DBG_ARB_TIMEOUT_EN
   ,
   output logic              timeout_o
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic [CMD_W-1:0]  cmd_d;
   logic [DATA_W-1:0] addr_d, data_d, m0_data_d, m1_data_d, fin_data;
   logic              m0_ready_d, m1_ready_d, grant_d, finish;
   logic              req0, req1, pick1;

`ifdef DBG_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_d;
`endif

   assign req0   = |m0_cmd_i;
   assign req1   = |m1_cmd_i;
   // prio_q high means requester 1 wins a simultaneous request
   assign pick1  = req1 & (~req0 | prio_q);
   assign busy_o = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      cmd_d      = dbg_cmd_o;
      addr_d     = dbg_addr_o;
      data_d     = dbg_data_o;
      m0_data_d  = m0_data_o;
      m1_data_d  = m1_data_o;
      m0_ready_d = 1'b0;
      m1_ready_d = 1'b0;
      grant_d    = grant_o;
      finish     = 1'b0;
      fin_data   = dbg_data_i;
`ifdef DBG_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            cmd_d = '0;
            if (req0 || req1) begin
               grant_d = pick1;
               cmd_d   = pick1 ? m1_cmd_i  : m0_cmd_i;
               addr_d  = pick1 ? m1_addr_i : m0_addr_i;
               data_d  = pick1 ? m1_data_i : m0_data_i;
               state_d = BUSY;
`ifdef DBG_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         BUSY: begin
            finish = dbg_ready_i;
`ifdef DBG_ARB_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
            // a real answer in the same cycle always beats the watchdog
            if (!dbg_ready_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
               finish    = 1'b1;
               fin_data  = DATA_W'(32'hDEADBEEF);
               timeout_d = 1'b1;
            end
`endif
            if (finish) begin
               cmd_d   = '0;
               prio_d  = ~grant_o;
               state_d = DONE;
               if (grant_o) begin
                  m1_data_d  = fin_data;
                  m1_ready_d = 1'b1;
               end else begin
                  m0_data_d  = fin_data;
                  m0_ready_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cmd_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         prio_q     <= 1'b0;
         dbg_cmd_o  <= '0;
         dbg_addr_o <= '0;
         dbg_data_o <= '0;
         m0_data_o  <= '0;
         m1_data_o  <= '0;
         m0_ready_o <= 1'b0;
         m1_ready_o <= 1'b0;
         grant_o    <= 1'b0;
      end else begin
         prio_q     <= prio_d;
         dbg_cmd_o  <= cmd_d;
         dbg_addr_o <= addr_d;
         dbg_data_o <= data_d;
         m0_data_o  <= m0_data_d;
         m1_data_o  <= m1_data_d;
         m0_ready_o <= m0_ready_d;
         m1_ready_o <= m1_ready_d;
         grant_o    <= grant_d;
      end
   end

`ifdef DBG_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_o <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_o <= timeout_d;
      end
   end
`endif

endmodule

// File: tb/tb_dbg_port_arbiter.sv
// Scoreboard bench for dbg_port_arbiter: directed transactions push expected
// completions into a queue that a negedge monitor pops on every ready pulse.
module tb_dbg_port_arbiter;

   localparam int DATA_W = 32;
   localparam int CMD_W  = 8;
   localparam logic [31:0] RESP_KEY = 32'h0F0F_0000;

   logic              clk;
   logic              rst_i;
   logic [CMD_W-1:0]  m0_cmd_i, m1_cmd_i, dbg_cmd_o;
   logic [DATA_W-1:0] m0_addr_i, m0_data_i, m0_data_o;
   logic [DATA_W-1:0] m1_addr_i, m1_data_i, m1_data_o;
   logic [DATA_W-1:0] dbg_addr_o, dbg_data_o, dbg_data_i;
   logic              m0_ready_o, m1_ready_o, dbg_ready_i, grant_o, busy_o;
`ifdef DBG_ARB_TIMEOUT_EN
   logic              timeout_o;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];
   bit          auto_resp = 1'b0;

   dbg_port_arbiter #(
      .DATA_W(DATA_W),
      .CMD_W (CMD_W)
`ifdef DBG_ARB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .m0_cmd_i   (m0_cmd_i),
      .m0_addr_i  (m0_addr_i),
      .m0_data_i  (m0_data_i),
      .m0_data_o  (m0_data_o),
      .m0_ready_o (m0_ready_o),
      .m1_cmd_i   (m1_cmd_i),
      .m1_addr_i  (m1_addr_i),
      .m1_data_i  (m1_data_i),
      .m1_data_o  (m1_data_o),
      .m1_ready_o (m1_ready_o),
      .dbg_cmd_o  (dbg_cmd_o),
      .dbg_addr_o (dbg_addr_o),
      .dbg_data_o (dbg_data_o),
      .dbg_data_i (dbg_data_i),
      .dbg_ready_i(dbg_ready_i),
      .grant_o    (grant_o),
      .busy_o     (busy_o)
`ifdef DBG_ARB_TIMEOUT_EN
      ,
      .timeout_o  (timeout_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit port, input logic [7:0] cmd, input logic [31:0] addr,
                                input logic [31:0] wdata);
      if (port) begin
         m1_cmd_i = cmd; m1_addr_i = addr; m1_data_i = wdata;
      end else begin
         m0_cmd_i = cmd; m0_addr_i = addr; m0_data_i = wdata;
      end
   endtask

   task automatic expectResp(input bit port, input logic [31:0] data);
      exp_q.push_back({port, data});
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic coreAnswer(input logic [31:0] data);
      dbg_ready_i = 1'b1;
      dbg_data_i  = data;
   endtask

   task automatic coreIdle();
      dbg_ready_i = 1'b0;
      dbg_data_i  = '0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_dbg_cmd"},  32'(dbg_cmd_o), 32'h0);
      checkOutput({tag, "_dbg_addr"}, dbg_addr_o, 32'h0);
      checkOutput({tag, "_dbg_data"}, dbg_data_o, 32'h0);
      checkOutput({tag, "_m0_data"},  m0_data_o, 32'h0);
      checkOutput({tag, "_m1_data"},  m1_data_o, 32'h0);
      checkOutput({tag, "_m0_ready"}, 32'(m0_ready_o), 32'h0);
      checkOutput({tag, "_m1_ready"}, 32'(m1_ready_o), 32'h0);
      checkOutput({tag, "_grant"},    32'(grant_o), 32'h0);
      checkOutput({tag, "_busy"},     32'(busy_o), 32'h0);
`ifdef DBG_ARB_TIMEOUT_EN
      checkOutput({tag, "_timeout"},  32'(timeout_o), 32'h0);
`endif
   endtask

   // Core model for the round-robin phase: answers in the cycle the command appears.
   always @(posedge clk) begin
      #1;
      if (auto_resp) begin
         dbg_ready_i = (dbg_cmd_o != '0);
         dbg_data_i  = dbg_addr_o ^ RESP_KEY;
      end
   end

   always @(negedge clk) begin
      logic [32:0] e;
      logic [32:0] got;
      if (!rst_i && (m0_ready_o || m1_ready_o)) begin
         checks++;
         got = m1_ready_o ? {1'b1, m1_data_o} : {1'b0, m0_data_o};
         if (m0_ready_o && m1_ready_o) begin
            failures++;
            $display("[TB] FAIL both_ready actual=11 required=one_hot");
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_ready actual=%h required=no_pulse", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               failures++;
               $display("[TB] FAIL scoreboard actual=%h required=%h", got, e);
            end
         end
      end
   end

   initial begin
      logic [31:0] a0, a1, last_m0;
      bit          p;
      rst_i = 1'b1;
      applyStimulus(0, 8'h00, 32'h0, 32'h0);
      applyStimulus(1, 8'h00, 32'h0, 32'h0);
      coreIdle();
      step(2);
      checkAllZero("reset");
      rst_i = 1'b0;

      // single m0 read, core answers in cycle 4
      step();
      applyStimulus(0, 8'h02, 32'h100, 32'h1111_2222);
      step();
      checkOutput("t1_cmd",   32'(dbg_cmd_o), 32'h02);
      checkOutput("t1_addr",  dbg_addr_o, 32'h100);
      checkOutput("t1_wdata", dbg_data_o, 32'h1111_2222);
      checkOutput("t1_grant", 32'(grant_o), 32'h0);
      checkOutput("t1_busy",  32'(busy_o), 32'h1);
      step(2);
      checkOutput("t1_cmd_hold", 32'(dbg_cmd_o), 32'h02);
      step();
      coreAnswer(32'hCAFE_0001);
      expectResp(0, 32'hCAFE_0001);
      step();
      coreIdle();
      checkOutput("t1_ready_c5", 32'(m0_ready_o), 32'h1);
      checkOutput("t1_data_c5",  m0_data_o, 32'hCAFE_0001);
      checkOutput("t1_cmd_done", 32'(dbg_cmd_o), 32'h0);
      checkOutput("t1_m1_data",  m1_data_o, 32'h0);
      checkOutput("t1_m1_ready", 32'(m1_ready_o), 32'h0);
      applyStimulus(0, 8'h00, 32'h0, 32'h0);
      step();
      checkOutput("t1_idle_busy", 32'(busy_o), 32'h0);
      checkOutput("t1_data_hold", m0_data_o, 32'hCAFE_0001);

      // m1 arrives while m0 is BUSY and must wait for the IDLE after DONE
      applyStimulus(0, 8'h04, 32'h200, 32'h0);
      step();
      checkOutput("t3_grant0", 32'(grant_o), 32'h0);
      applyStimulus(1, 8'h05, 32'h300, 32'h33);
      step();
      checkOutput("t3_addr_held", dbg_addr_o, 32'h200);
      coreAnswer(32'hCAFE_0002);
      expectResp(0, 32'hCAFE_0002);
      step();
      coreIdle();
      applyStimulus(0, 8'h00, 32'h0, 32'h0);
      checkOutput("t3_done_addr", dbg_addr_o, 32'h200);
      step();
      checkOutput("t3_idle_addr",  dbg_addr_o, 32'h200);
      checkOutput("t3_idle_grant", 32'(grant_o), 32'h0);
      step();
      checkOutput("t3_grant1", 32'(grant_o), 32'h1);
      checkOutput("t3_addr1",  dbg_addr_o, 32'h300);
      checkOutput("t3_cmd1",   32'(dbg_cmd_o), 32'h05);
      checkOutput("t3_m1_untouched", m1_data_o, 32'h0);
      coreAnswer(32'hCAFE_0003);
      expectResp(1, 32'hCAFE_0003);
      step();
      coreIdle();
      applyStimulus(1, 8'h00, 32'h0, 32'h0);
      checkOutput("t3_m0_untouched", m0_data_o, 32'hCAFE_0002);
      step();

      // both requesters contend continuously; grants alternate every 3 cycles
      a0 = 32'hA0; a1 = 32'hB0; last_m0 = 32'h0;
      applyStimulus(0, 8'h01, a0, 32'h0);
      applyStimulus(1, 8'h03, a1, 32'h0);
      auto_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p = i[0];
         expectResp(p, (p ? a1 : a0) ^ RESP_KEY);
         if (!p) last_m0 = a0 ^ RESP_KEY;
         step();
         checkOutput($sformatf("rr_grant%0d", i), 32'(grant_o), 32'(p));
         checkOutput($sformatf("rr_addr%0d", i), dbg_addr_o, p ? a1 : a0);
         step();
         if (i >= 2) begin
            applyStimulus(p, 8'h00, 32'h0, 32'h0);
         end else if (p) begin
            a1 = a1 + 32'h10; applyStimulus(1, 8'h03, a1, 32'h0);
         end else begin
            a0 = a0 + 32'h10; applyStimulus(0, 8'h01, a0, 32'h0);
         end
         step();
      end
      auto_resp = 1'b0;
      coreIdle();

      // spurious core ready while IDLE
      coreAnswer(32'hFFFF_0000);
      step();
      checkOutput("spur_busy", 32'(busy_o), 32'h0);
      checkOutput("spur_cmd",  32'(dbg_cmd_o), 32'h0);
      step();
      checkOutput("spur_busy2", 32'(busy_o), 32'h0);
      checkOutput("spur_m0_data", m0_data_o, last_m0);
      coreIdle();
      step();

      // reset in the middle of a BUSY transaction
      applyStimulus(0, 8'h06, 32'h400, 32'h0);
      step();
      checkOutput("rst_pre_busy", 32'(busy_o), 32'h1);
      #2 rst_i = 1'b1;
      #1 checkAllZero("midrst");
      applyStimulus(1, 8'h07, 32'h500, 32'h0);
      step();
      rst_i = 1'b0;
      step();
      checkOutput("rst_post_grant", 32'(grant_o), 32'h0);
      checkOutput("rst_post_addr",  dbg_addr_o, 32'h400);
      coreAnswer(32'hCAFE_0004);
      expectResp(0, 32'hCAFE_0004);
      step();
      coreIdle();
      applyStimulus(0, 8'h00, 32'h0, 32'h0);
      step(2);
      checkOutput("rst_m1_grant", 32'(grant_o), 32'h1);
      checkOutput("rst_m1_addr",  dbg_addr_o, 32'h500);
      coreAnswer(32'hCAFE_0005);
      expectResp(1, 32'hCAFE_0005);
      step();
      coreIdle();
      applyStimulus(1, 8'h00, 32'h0, 32'h0);
      step();

`ifdef DBG_ARB_TIMEOUT_EN
      // core never answers: abort after 16 BUSY cycles
      applyStimulus(0, 8'h08, 32'h600, 32'h0);
      step();
      expectResp(0, 32'hDEAD_BEEF);
      step(15);
      checkOutput("to_c16_timeout", 32'(timeout_o), 32'h0);
      checkOutput("to_c16_ready",   32'(m0_ready_o), 32'h0);
      checkOutput("to_c16_busy",    32'(busy_o), 32'h1);
      step();
      checkOutput("to_c17_timeout", 32'(timeout_o), 32'h1);
      checkOutput("to_c17_ready",   32'(m0_ready_o), 32'h1);
      checkOutput("to_c17_data",    m0_data_o, 32'hDEAD_BEEF);
      checkOutput("to_c17_cmd",     32'(dbg_cmd_o), 32'h0);
      applyStimulus(0, 8'h00, 32'h0, 32'h0);
      applyStimulus(1, 8'h09, 32'h700, 32'h0);
      step();
      checkOutput("to_c18_timeout", 32'(timeout_o), 32'h0);
      step();
      checkOutput("to_m1_grant", 32'(grant_o), 32'h1);
      checkOutput("to_m1_addr",  dbg_addr_o, 32'h700);
      coreAnswer(32'hCAFE_0006);
      expectResp(1, 32'hCAFE_0006);
      step();
      coreIdle();
      applyStimulus(1, 8'h00, 32'h0, 32'h0);
      checkOutput("to_m1_no_timeout", 32'(timeout_o), 32'h0);
      step();
`endif

      step(2);
      checkOutput("pending_responses", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
